mycpu_mem_arbiter: RTL and testbench

Shares one single-ported 16-bit memory/IO bus between NREQ requesters: CPU instruction/data port, DMA loader and debug port. Arbitration is round-robin with a req/gnt/ack handshake. A fixed-latency access sequencer drives the memory side. Sits between the mycpu core/peripherals and the memory macro, on the path that carries a_out/d_out/wen_out/iom_out today.

---
 rtl/mycpu_pkg.sv | 15 +
 rtl/mycpu_rr_pick.sv | 40 ++++
 rtl/mycpu_mem_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mycpu_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mycpu_pkg.sv
// Shared mycpu types and constants.
// Holds the memory arbiter state encoding and sizing limits.
package mycpu_pkg;

   localparam int ARB_MAX_REQ = 8;
   localparam int ARB_CNT_W   = 3;
   localparam int ARB_IDX_W   = $clog2(ARB_MAX_REQ);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_t;

endpackage

// File: rtl/mycpu_rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping.
// Ports: req (requests), ptr (search start), gnt (one-hot winner),
//        idx (winner index), vld (any request present).
module mycpu_rr_pick
   import mycpu_pkg::*;
#(
   parameter int NREQ = 2
) (
   input  logic [NREQ-1:0]      req,
   input  logic [ARB_IDX_W-1:0] ptr,
   output logic [NREQ-1:0]      gnt,
   output logic [ARB_IDX_W-1:0] idx,
   output logic                 vld
);

   logic [2*NREQ-1:0]  dbl;
   logic [NREQ-1:0]    rot;
   logic [ARB_IDX_W:0] sum;

   // Rotate so bit 0 is the requester at ptr, find the first set
   // bit, then rotate the position back into an absolute index.
   always_comb begin
      dbl = {req, req} >> ptr;
      rot = dbl[NREQ-1:0];
      vld = 1'b0;
      sum = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!vld && rot[k]) begin
            vld = 1'b1;
            sum = {1'b0, ptr} + (ARB_IDX_W+1)'(k);
         end
      end
      if (sum >= (ARB_IDX_W+1)'(NREQ)) begin
         sum = sum - (ARB_IDX_W+1)'(NREQ);
      end
      idx = sum[ARB_IDX_W-1:0];
      gnt = vld ? (NREQ'(1) << idx) : '0;
   end

endmodule

// File: rtl/mycpu_mem_arbiter.sv
// Round-robin arbiter sharing one 16-bit memory/IO bus among NREQ
// requesters with req/gnt/ack handshake and fixed-latency access.
// Ports: clk, rst (sync, active-high); req/wen/iom/a/d_in per
// requester; gnt_out, ack_out, rdata_out back to requesters;
// mem_a/d/wen/iom/en_out and mem_d_in to the memory; busy_out.
// Build option MYCPU_ARB_LOCK_EN adds lock_in[NREQ]: a locked
// winner keeps priority for the next arbitration.
module mycpu_mem_arbiter
   import mycpu_pkg::*;
#(
   parameter int NREQ        = 2,
   parameter int MEM_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  rst,
`ifdef MYCPU_ARB_LOCK_EN
   input  logic [NREQ-1:0]       lock_in,
`endif
   input  logic [NREQ-1:0]       req_in,
   input  logic [NREQ-1:0]       wen_in,
   input  logic [NREQ-1:0]       iom_in,
   input  logic [NREQ-1:0][15:0] a_in,
   input  logic [NREQ-1:0][15:0] d_in,
   output logic [NREQ-1:0]       gnt_out,
   output logic [NREQ-1:0]       ack_out,
   output logic [15:0]           rdata_out,
   output logic [15:0]           mem_a_out,
   output logic [15:0]           mem_d_out,
   output logic                  mem_wen_out,
   output logic                  mem_iom_out,
   output logic                  mem_en_out,
   input  logic [15:0]           mem_d_in,
   output logic                  busy_out
);

   arb_state_t           state_q, state_d;
   logic [ARB_IDX_W-1:0] ptr_q, ptr_d;
   logic [ARB_IDX_W-1:0] win_q, win_d;
   logic [ARB_CNT_W-1:0] cnt_q, cnt_d;
   logic [NREQ-1:0]      gnt_q, gnt_d;
   logic [NREQ-1:0]      ack_q, ack_d;
   logic [15:0]          rdata_q, rdata_d;
   logic [15:0]          mem_a_q, mem_a_d;
   logic [15:0]          mem_d_q, mem_d_d;
   logic                 mem_wen_q, mem_wen_d;
   logic                 mem_iom_q, mem_iom_d;
   logic                 mem_en_q, mem_en_d;

   logic [NREQ-1:0]      pick_gnt;
   logic [ARB_IDX_W-1:0] pick_idx;
   logic                 pick_vld;
   logic [15:0]          sel_a, sel_d;
   logic                 sel_wen, sel_iom;

   mycpu_rr_pick #(.NREQ(NREQ)) u_pick (
      .req (req_in),
      .ptr (ptr_q),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .vld (pick_vld)
   );

   always_comb begin
      sel_a   = '0;
      sel_d   = '0;
      sel_wen = 1'b0;
      sel_iom = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (pick_gnt[i]) begin
            sel_a   = a_in[i];
            sel_d   = d_in[i];
            sel_wen = wen_in[i];
            sel_iom = iom_in[i];
         end
      end
   end

   // The mem_* registers double as the latched request: they are
   // loaded on ACCESS entry and cleared on exit, so the bus is quiet
   // outside ACCESS.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      win_d     = win_q;
      cnt_d     = cnt_q;
      gnt_d     = gnt_q;
      ack_d     = '0;
      rdata_d   = rdata_q;
      mem_a_d   = mem_a_q;
      mem_d_d   = mem_d_q;
      mem_wen_d = mem_wen_q;
      mem_iom_d = mem_iom_q;
      mem_en_d  = mem_en_q;
      unique case (state_q)
         IDLE: begin
            if (pick_vld) begin
               state_d   = ACCESS;
               gnt_d     = pick_gnt;
               win_d     = pick_idx;
               mem_a_d   = sel_a;
               mem_d_d   = sel_d;
               mem_wen_d = sel_wen;
               mem_iom_d = sel_iom;
               mem_en_d  = 1'b1;
               cnt_d     = sel_wen ? '0
                                   : ARB_CNT_W'(MEM_LATENCY-1);
            end
         end
         ACCESS: begin
            if (cnt_q == '0) begin
               state_d   = RESP;
               rdata_d   = mem_wen_q ? '0 : mem_d_in;
               ack_d     = gnt_q;
               mem_a_d   = '0;
               mem_d_d   = '0;
               mem_wen_d = 1'b0;
               mem_iom_d = 1'b0;
               mem_en_d  = 1'b0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESP: begin
            state_d = IDLE;
            gnt_d   = '0;
            rdata_d = '0;
            if (win_q == ARB_IDX_W'(NREQ-1)) begin
               ptr_d = '0;
            end else begin
               ptr_d = win_q + 1'b1;
            end
`ifdef MYCPU_ARB_LOCK_EN
            // Holding the pointer on the winner gives it first pick.
            if (|(lock_in & gnt_q)) begin
               ptr_d = win_q;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         win_q     <= '0;
         cnt_q     <= '0;
         gnt_q     <= '0;
         ack_q     <= '0;
         rdata_q   <= '0;
         mem_a_q   <= '0;
         mem_d_q   <= '0;
         mem_wen_q <= 1'b0;
         mem_iom_q <= 1'b0;
         mem_en_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         win_q     <= win_d;
         cnt_q     <= cnt_d;
         gnt_q     <= gnt_d;
         ack_q     <= ack_d;
         rdata_q   <= rdata_d;
         mem_a_q   <= mem_a_d;
         mem_d_q   <= mem_d_d;
         mem_wen_q <= mem_wen_d;
         mem_iom_q <= mem_iom_d;
         mem_en_q  <= mem_en_d;
      end
   end

   assign gnt_out     = gnt_q;
   assign ack_out     = ack_q;
   assign rdata_out   = rdata_q;
   assign mem_a_out   = mem_a_q;
   assign mem_d_out   = mem_d_q;
   assign mem_wen_out = mem_wen_q;
   assign mem_iom_out = mem_iom_q;
   assign mem_en_out  = mem_en_q;
   assign busy_out    = (state_q != IDLE);

endmodule

// File: tb/tb_mycpu_mem_arbiter.sv
// Bench for mycpu_mem_arbiter: timeline model plus directed checks.
// Define MYCPU_ARB_LOCK_EN to also exercise the lock option.
module tb_mycpu_mem_arbiter;

   localparam int NREQ = 2;
   localparam int ML   = 2;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [NREQ-1:0]       req_in = '0;
   logic [NREQ-1:0]       wen_in = '0;
   logic [NREQ-1:0]       iom_in = '0;
   logic [NREQ-1:0][15:0] a_in = '0;
   logic [NREQ-1:0][15:0] d_in = '0;
   logic [15:0]           mem_d_in = '0;
`ifdef MYCPU_ARB_LOCK_EN
   logic [NREQ-1:0]       lock_in = '0;
`endif
   logic [NREQ-1:0]       gnt_out, ack_out;
   logic [15:0]           rdata_out, mem_a_out, mem_d_out;
   logic                  mem_wen_out, mem_iom_out, mem_en_out;
   logic                  busy_out;

   mycpu_mem_arbiter #(.NREQ(NREQ), .MEM_LATENCY(ML)) dut (
      .clk         (clk),
      .rst         (rst),
`ifdef MYCPU_ARB_LOCK_EN
      .lock_in     (lock_in),
`endif
      .req_in      (req_in),
      .wen_in      (wen_in),
      .iom_in      (iom_in),
      .a_in        (a_in),
      .d_in        (d_in),
      .gnt_out     (gnt_out),
      .ack_out     (ack_out),
      .rdata_out   (rdata_out),
      .mem_a_out   (mem_a_out),
      .mem_d_out   (mem_d_out),
      .mem_wen_out (mem_wen_out),
      .mem_iom_out (mem_iom_out),
      .mem_en_out  (mem_en_out),
      .mem_d_in    (mem_d_in),
      .busy_out    (busy_out)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   task automatic cmp(input string nm, input logic [15:0] act,
                      input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Transaction timeline model: a transaction starting at edge st
   // with length len (ML for reads, 1 for writes) has its bus access
   // during edges st..st+len-1, ack at st+len, and frees the arbiter
   // at st+len+1.
   int          m_e = 0, m_st = 0, m_len = 0, m_win = 0, m_ptr = 0;
   int          rel;
   bit          m_act = 1'b0;
   logic [15:0] m_a, m_d, m_cap;
   logic        m_wr, m_iom;
   logic [NREQ-1:0] x_gnt = '0, x_ack = '0;
   logic [15:0] x_rdata = '0, x_a = '0, x_d = '0;
   logic        x_wen = 1'b0, x_iom = 1'b0, x_en = 1'b0, x_busy = 1'b0;

   always @(posedge clk) begin : model
      if (rst) begin
         m_act = 1'b0;
         m_ptr = 0;
      end else if (m_act && m_e == m_st + m_len) begin
         m_cap = m_wr ? 16'h0 : mem_d_in;
      end else if (m_act && m_e == m_st + m_len + 1) begin
         m_act = 1'b0;
         m_ptr = (m_win + 1) % NREQ;
`ifdef MYCPU_ARB_LOCK_EN
         if (lock_in[m_win]) m_ptr = m_win;
`endif
      end else if (!m_act) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!m_act && req_in[(m_ptr + i) % NREQ]) begin
               m_act = 1'b1;
               m_win = (m_ptr + i) % NREQ;
               m_st  = m_e;
               m_wr  = wen_in[m_win];
               m_iom = iom_in[m_win];
               m_a   = a_in[m_win];
               m_d   = d_in[m_win];
               m_len = m_wr ? 1 : ML;
            end
         end
      end
      x_gnt = '0; x_ack = '0; x_rdata = '0; x_a = '0; x_d = '0;
      x_wen = 1'b0; x_iom = 1'b0; x_en = 1'b0; x_busy = 1'b0;
      if (m_act) begin
         rel    = m_e - m_st;
         x_gnt  = NREQ'(1) << m_win;
         x_busy = 1'b1;
         if (rel < m_len) begin
            x_en = 1'b1; x_a = m_a; x_d = m_d;
            x_wen = m_wr; x_iom = m_iom;
         end else begin
            x_ack   = NREQ'(1) << m_win;
            x_rdata = m_cap;
         end
      end
      m_e++;
   end

   always @(negedge clk) begin : compare
      if (chk_en) begin
         cmp("gnt", 16'(gnt_out), 16'(x_gnt));
         cmp("ack", 16'(ack_out), 16'(x_ack));
         cmp("busy", 16'(busy_out), 16'(x_busy));
         cmp("mem_en", 16'(mem_en_out), 16'(x_en));
         cmp("mem_wen", 16'(mem_wen_out), 16'(x_wen));
         if (x_en) begin
            cmp("mem_a", mem_a_out, x_a);
            cmp("mem_d", mem_d_out, x_d);
            cmp("mem_iom", 16'(mem_iom_out), 16'(x_iom));
         end
         if (x_ack != '0) cmp("rdata", rdata_out, x_rdata);
      end
   end

   logic [NREQ-1:0] seq[4];
   int              cyc[4];
   logic [15:0]     rd0;
   int              acks;

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk_en = 1'b1;
      cmp("rst_gnt", 16'(gnt_out), 16'h0);
      cmp("rst_ack", 16'(ack_out), 16'h0);
      cmp("rst_rdata", rdata_out, 16'h0);
      cmp("rst_mem_a", mem_a_out, 16'h0);
      cmp("rst_mem_d", mem_d_out, 16'h0);
      cmp("rst_wen", 16'(mem_wen_out), 16'h0);
      cmp("rst_iom", 16'(mem_iom_out), 16'h0);
      cmp("rst_en", 16'(mem_en_out), 16'h0);
      cmp("rst_busy", 16'(busy_out), 16'h0);
      rst = 1'b0;
      step();

      // read by requester 0
      req_in = 2'b01; a_in[0] = 16'h0010; mem_d_in = 16'hBEEF;
      step();
      cmp("t1_gnt_c1", 16'(gnt_out), 16'h1);
      cmp("t1_en_c1", 16'(mem_en_out), 16'h1);
      cmp("t1_a_c1", mem_a_out, 16'h0010);
      step();
      cmp("t1_en_c2", 16'(mem_en_out), 16'h1);
      step();
      cmp("t1_ack_c3", 16'(ack_out), 16'h1);
      cmp("t1_rdata", rdata_out, 16'hBEEF);
      cmp("t1_gnt_c3", 16'(gnt_out), 16'h1);
      cmp("t1_en_c3", 16'(mem_en_out), 16'h0);
      req_in = '0;
      step();
      cmp("t1_idle", 16'(busy_out), 16'h0);

      // write by requester 1, request dropped before ack
      req_in = 2'b10; wen_in = 2'b10;
      a_in[1] = 16'h0020; d_in[1] = 16'h1234;
      step();
      cmp("t2_wen", 16'(mem_wen_out), 16'h1);
      cmp("t2_a", mem_a_out, 16'h0020);
      cmp("t2_d", mem_d_out, 16'h1234);
      req_in = '0;
      step();
      cmp("t2_ack", 16'(ack_out), 16'h2);
      cmp("t2_rdata", rdata_out, 16'h0000);
      cmp("t2_wen_off", 16'(mem_wen_out), 16'h0);
      step();

      // both requesters held high: grants alternate
      wen_in = '0; req_in = 2'b11;
      a_in[0] = 16'h0100; a_in[1] = 16'h0200;
      acks = 0;
      for (int c = 0; c < 40 && acks < 4; c++) begin
         mem_d_in = 16'h1000 + 16'(c);
         step();
         if (ack_out != '0) begin
            seq[acks] = ack_out;
            cyc[acks] = c;
            if (acks == 0) rd0 = rdata_out;
            acks++;
         end
      end
      req_in = '0;
      cmp("t3_acks", 16'(acks), 16'd4);
      if (acks == 4) begin
         cmp("t3_seq0", 16'(seq[0]), 16'h1);
         cmp("t3_seq1", 16'(seq[1]), 16'h2);
         cmp("t3_seq2", 16'(seq[2]), 16'h1);
         cmp("t3_seq3", 16'(seq[3]), 16'h2);
         cmp("t3_first", 16'(cyc[0]), 16'd2);
         cmp("t3_rd0", rd0, 16'h1002);
         for (int k = 1; k < 4; k++) begin
            cmp("t3_gap", 16'(cyc[k] - cyc[k-1]), 16'd4);
         end
      end
      step();

      // IO read, inputs changed mid-access
      req_in = 2'b01; iom_in = 2'b01; a_in[0] = 16'h0003;
      step();
      cmp("t4_iom_c1", 16'(mem_iom_out), 16'h1);
      cmp("t4_a_c1", mem_a_out, 16'h0003);
      a_in[0] = 16'hFFFF; iom_in = '0;
      step();
      cmp("t4_iom_c2", 16'(mem_iom_out), 16'h1);
      cmp("t4_a_c2", mem_a_out, 16'h0003);
      step();
      cmp("t4_ack", 16'(ack_out), 16'h1);
      req_in = '0;
      step();

      // reset during second ACCESS cycle of requester 1
      req_in = 2'b10; a_in[1] = 16'h0040;
      step();
      cmp("t5_gnt", 16'(gnt_out), 16'h2);
      step();
      rst = 1'b1;
      step();
      cmp("t5_gnt_rst", 16'(gnt_out), 16'h0);
      cmp("t5_ack_rst", 16'(ack_out), 16'h0);
      cmp("t5_en_rst", 16'(mem_en_out), 16'h0);
      cmp("t5_busy_rst", 16'(busy_out), 16'h0);
      rst = 1'b0; req_in = 2'b11;
      step();
      cmp("t5_gnt_after", 16'(gnt_out), 16'h1);
      step();
      step();
      cmp("t5_ack_after", 16'(ack_out), 16'h1);
      req_in = '0;
      step();

`ifdef MYCPU_ARB_LOCK_EN
      // lock on requester 0 keeps it granted until released
      lock_in = 2'b01; req_in = 2'b11;
      acks = 0;
      for (int c = 0; c < 60 && acks < 4; c++) begin
         step();
         if (ack_out != '0) begin
            seq[acks] = ack_out;
            acks++;
            if (acks == 3) lock_in = '0;
         end
      end
      req_in = '0;
      cmp("t6_acks", 16'(acks), 16'd4);
      if (acks == 4) begin
         cmp("t6_seq0", 16'(seq[0]), 16'h2);
         cmp("t6_seq1", 16'(seq[1]), 16'h1);
         cmp("t6_seq2", 16'(seq[2]), 16'h1);
         cmp("t6_seq3", 16'(seq[3]), 16'h2);
      end
      step();
`endif

      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
